// File: rtl/ddr3_rw_arbiter_if.sv
// Bundle of every requester-side and DDR3 IP-side signal handled by ddr3_rw_arbiter.
// master : arbiter view (drives grants, strobes and the IP command/data ports)
// slave  : environment view (requesters, FIFOs and the DDR3 IP)
// Requester side: init_calib_complete, wr_/rd_ req, addr, burst, grant, done, FIFO strobes/data
// IP side       : cmd_ready, cmd, cmd_en, app_burst_number, addr, wr_data_rdy/en/end,
//                 wr_data, wr_data_mask, rd_data_valid, rd_data
interface ddr3_rw_arbiter_if #(
   parameter int unsigned ADDR_WIDTH = 28,
   parameter int unsigned DATA_WIDTH = 128
);
   logic                    init_calib_complete;
   logic                    wr_req;
   logic [ADDR_WIDTH-1:0]   wr_addr;
   logic [5:0]              wr_burst;
   logic                    wr_grant;
   logic                    wr_fifo_rd;
   logic [DATA_WIDTH-1:0]   wr_fifo_data;
   logic                    wr_done;
   logic                    rd_req;
   logic [ADDR_WIDTH-1:0]   rd_addr;
   logic [5:0]              rd_burst;
   logic                    rd_urgent;
   logic                    rd_grant;
   logic                    rd_fifo_wr;
   logic [DATA_WIDTH-1:0]   rd_fifo_data;
   logic                    rd_done;
   logic                    cmd_ready;
   logic [2:0]              cmd;
   logic                    cmd_en;
   logic [5:0]              app_burst_number;
   logic [ADDR_WIDTH-1:0]   addr;
   logic                    wr_data_rdy;
   logic                    wr_data_en;
   logic                    wr_data_end;
   logic [DATA_WIDTH-1:0]   wr_data;
   logic [DATA_WIDTH/8-1:0] wr_data_mask;
   logic                    rd_data_valid;
   logic [DATA_WIDTH-1:0]   rd_data;

   modport master (
      input  init_calib_complete, wr_req, wr_addr, wr_burst, wr_fifo_data,
             rd_req, rd_addr, rd_burst, rd_urgent, cmd_ready, wr_data_rdy,
             rd_data_valid, rd_data,
      output wr_grant, wr_fifo_rd, wr_done, rd_grant, rd_fifo_wr, rd_fifo_data,
             rd_done, cmd, cmd_en, app_burst_number, addr, wr_data_en,
             wr_data_end, wr_data, wr_data_mask
   );

   modport slave (
      output init_calib_complete, wr_req, wr_addr, wr_burst, wr_fifo_data,
             rd_req, rd_addr, rd_burst, rd_urgent, cmd_ready, wr_data_rdy,
             rd_data_valid, rd_data,
      input  wr_grant, wr_fifo_rd, wr_done, rd_grant, rd_fifo_wr, rd_fifo_data,
             rd_done, cmd, cmd_en, app_burst_number, addr, wr_data_en,
             wr_data_end, wr_data, wr_data_mask
   );
endinterface

// File: rtl/ddr3_rw_arbiter.sv
// Shares the single DDR3 IP application port between one write requester (camera ingest
// FIFO) and one read requester (video prefetch FIFO). Grants whole bursts, streams write
// beats before the write command, counts read beats back and pulses completion.
// Ports: clk, rst_n (async active-low), bus (ddr3_rw_arbiter_if.master, all handshakes).
module ddr3_rw_arbiter #(
   parameter int unsigned ADDR_WIDTH = 28,
   parameter int unsigned DATA_WIDTH = 128,
   parameter int unsigned CMD_WR     = 0,
   parameter int unsigned CMD_RD     = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   ddr3_rw_arbiter_if.master         bus
);
   localparam int unsigned BURST_W = 6;
   localparam int unsigned MASK_W  = DATA_WIDTH / 8;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WR_DATA = 3'd1;
   localparam logic [2:0] S_WR_CMD  = 3'd2;
   localparam logic [2:0] S_RD_CMD  = 3'd3;
   localparam logic [2:0] S_RD_WAIT = 3'd4;

   logic [2:0]            state_q, state_d;
   logic [BURST_W-1:0]    cnt_q, cnt_d;
   logic [BURST_W-1:0]    burst_q, burst_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  last_rd_q, last_rd_d;
   logic                  run_q;

   logic                  pick_wr, pick_rd;
   logic                  wr_grant_c, rd_grant_c, wr_done_c, rd_done_c;
   logic                  wr_beat_c, rd_beat_c, cmd_en_c;
   logic [2:0]            cmd_c;

   // Arbitration decision; run_q keeps grants low while reset is (or was just) asserted.
   always_comb begin
      pick_wr = 1'b0;
      pick_rd = 1'b0;
      if (run_q && bus.init_calib_complete) begin
         if (bus.rd_req && bus.rd_urgent) begin
            pick_rd = 1'b1;
         end else if (bus.wr_req && bus.rd_req) begin
            pick_rd = !last_rd_q;
            pick_wr = last_rd_q;
         end else if (bus.wr_req) begin
            pick_wr = 1'b1;
         end else if (bus.rd_req) begin
            pick_rd = 1'b1;
         end
      end
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      burst_d    = burst_q;
      addr_d     = addr_q;
      last_rd_d  = last_rd_q;
      wr_grant_c = 1'b0;
      rd_grant_c = 1'b0;
      wr_done_c  = 1'b0;
      rd_done_c  = 1'b0;
      wr_beat_c  = 1'b0;
      rd_beat_c  = 1'b0;
      cmd_en_c   = 1'b0;
      cmd_c      = 3'(CMD_WR);
      case (state_q)
         S_IDLE: begin
            if (pick_wr) begin
               wr_grant_c = 1'b1;
               addr_d     = bus.wr_addr;
               burst_d    = bus.wr_burst;
               last_rd_d  = 1'b0;
               cnt_d      = '0;
               state_d    = S_WR_DATA;
            end else if (pick_rd) begin
               rd_grant_c = 1'b1;
               addr_d     = bus.rd_addr;
               burst_d    = bus.rd_burst;
               last_rd_d  = 1'b1;
               cnt_d      = '0;
               state_d    = S_RD_CMD;
            end
         end
         S_WR_DATA: begin
            // One BL8 beat per cycle the IP accepts write data.
            wr_beat_c = bus.wr_data_rdy;
            if (wr_beat_c) begin
               cnt_d = cnt_q + BURST_W'(1);
               if (cnt_q == burst_q) state_d = S_WR_CMD;
            end
         end
         S_WR_CMD: begin
            cmd_en_c = 1'b1;
            cmd_c    = 3'(CMD_WR);
            if (bus.cmd_ready) begin
               wr_done_c = 1'b1;
               state_d   = S_IDLE;
            end
         end
         S_RD_CMD: begin
            cmd_en_c = 1'b1;
            cmd_c    = 3'(CMD_RD);
            if (bus.cmd_ready) state_d = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            rd_beat_c = bus.rd_data_valid;
            if (rd_beat_c) begin
               cnt_d = cnt_q + BURST_W'(1);
               if (cnt_q == burst_q) begin
                  rd_done_c = 1'b1;
                  state_d   = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register; last grant resets to read so the first tie goes to write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         burst_q   <= '0;
         addr_q    <= '0;
         last_rd_q <= 1'b1;
         run_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         burst_q   <= burst_d;
         addr_q    <= addr_d;
         last_rd_q <= last_rd_d;
         run_q     <= 1'b1;
      end
   end

   assign bus.wr_grant         = wr_grant_c;
   assign bus.rd_grant         = rd_grant_c;
   assign bus.wr_done          = wr_done_c;
   assign bus.rd_done          = rd_done_c;
   assign bus.wr_fifo_rd       = wr_beat_c;
   assign bus.wr_data_en       = wr_beat_c;
   assign bus.wr_data_end      = wr_beat_c;
   assign bus.wr_data          = bus.wr_fifo_data;
   assign bus.wr_data_mask     = {MASK_W{1'b0}};
   assign bus.rd_fifo_wr       = rd_beat_c;
   assign bus.rd_fifo_data     = bus.rd_data;
   assign bus.cmd_en           = cmd_en_c;
   assign bus.cmd              = cmd_c;
   assign bus.addr             = addr_q;
   assign bus.app_burst_number = burst_q;
endmodule

// File: tb/tb_ddr3_rw_arbiter.sv
// Directed bench for ddr3_rw_arbiter: arbitration table plus multi-cycle sequences.
module tb_ddr3_rw_arbiter;
   logic clk;
   logic rst_n;
   int   n_total;
   int   n_pass;

   ddr3_rw_arbiter_if bus ();
   ddr3_rw_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   typedef struct {
      logic calib;
      logic wr;
      logic rd;
      logic urg;
      logic exp_wg;
      logic exp_rg;
   } vec_t;
   vec_t vt [9];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Called at +1 of a cycle with inputs driven; returns at +3 of the grant cycle.
   task automatic wait_grant(output logic w, output logic r, output int waited);
      logic found;
      found = 1'b0; w = 1'b0; r = 1'b0; waited = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         #2;
         if (bus.wr_grant || bus.rd_grant) begin
            w = bus.wr_grant; r = bus.rd_grant; found = 1'b1;
         end else begin
            cyc();
            waited++;
         end
      end
      if (!found) begin
         chk("grant_timeout", 64'd0, 64'd1);
         #2;
      end
   endtask

   // Drives an always-ready IP until the current transaction completes; ends at +1 of IDLE.
   task automatic finish_txn();
      logic done;
      done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         cyc();
         bus.wr_data_rdy = 1'b1; bus.cmd_ready = 1'b1; bus.rd_data_valid = 1'b1;
         #2;
         if (bus.wr_done || bus.rd_done) done = 1'b1;
      end
      if (!done) chk("txn_timeout", 64'd0, 64'd1);
      cyc();
      bus.wr_data_rdy = 1'b0; bus.cmd_ready = 1'b0; bus.rd_data_valid = 1'b0;
   endtask

   initial begin
      logic w, r;
      int   waited, beats, dones, bad, done_ok, pass_bad;
      logic fin;

      n_total = 0; n_pass = 0;
      // calib, wr, rd, urg -> expected wr_grant, rd_grant (last grant = write on entry)
      vt[0] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      vt[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      vt[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      vt[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      vt[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      vt[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      vt[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      vt[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

      // Reset with hostile inputs: nothing may move.
      rst_n = 1'b0;
      bus.init_calib_complete = 1'b1;
      bus.wr_req = 1'b1; bus.wr_addr = '0; bus.wr_burst = '0; bus.wr_fifo_data = '0;
      bus.rd_req = 1'b1; bus.rd_addr = '0; bus.rd_burst = '0; bus.rd_urgent = 1'b1;
      bus.cmd_ready = 1'b1; bus.wr_data_rdy = 1'b1; bus.rd_data_valid = 1'b1; bus.rd_data = '0;
      repeat (3) cyc();
      #2;
      chk("rst_wr_grant", 64'(bus.wr_grant), 64'd0);
      chk("rst_rd_grant", 64'(bus.rd_grant), 64'd0);
      chk("rst_cmd_en", 64'(bus.cmd_en), 64'd0);
      chk("rst_cmd", 64'(bus.cmd), 64'd0);
      chk("rst_addr", 64'(bus.addr), 64'd0);
      chk("rst_abn", 64'(bus.app_burst_number), 64'd0);
      chk("rst_wr_data_en", 64'(bus.wr_data_en), 64'd0);
      chk("rst_rd_fifo_wr", 64'(bus.rd_fifo_wr), 64'd0);
      chk("rst_dones", 64'({bus.wr_done, bus.rd_done}), 64'd0);
      chk("rst_mask", 64'(bus.wr_data_mask), 64'd0);

      // 1: single write burst of 4 beats.
      cyc();
      rst_n = 1'b1;
      bus.rd_req = 1'b0; bus.rd_urgent = 1'b0; bus.rd_data_valid = 1'b0; bus.cmd_ready = 1'b0;
      bus.wr_req = 1'b1; bus.wr_addr = 28'h0001000; bus.wr_burst = 6'd3; bus.wr_data_rdy = 1'b1;
      wait_grant(w, r, waited);
      chk("t1_grant", 64'({w, r}), 64'b10);
      cyc();
      bus.wr_req = 1'b0;
      for (int b = 0; b < 4; b++) begin
         bus.wr_fifo_data = 128'(b + 100);
         #2;
         chk("t1_beat_en", 64'({bus.wr_data_en, bus.wr_data_end, bus.wr_fifo_rd}), 64'b111);
         chk("t1_wr_data", bus.wr_data[63:0], 64'(b + 100));
         cyc();
      end
      #2;
      chk("t1_cmd_en", 64'(bus.cmd_en), 64'd1);
      chk("t1_cmd", 64'(bus.cmd), 64'd0);
      chk("t1_addr", 64'(bus.addr), 64'h0001000);
      chk("t1_abn", 64'(bus.app_burst_number), 64'd3);
      chk("t1_no_extra_beat", 64'(bus.wr_data_en), 64'd0);
      chk("t1_no_done_yet", 64'(bus.wr_done), 64'd0);
      cyc();
      bus.cmd_ready = 1'b1;
      #2;
      chk("t1_wr_done", 64'({bus.wr_done, bus.cmd_en}), 64'b11);
      cyc();
      bus.cmd_ready = 1'b0; bus.wr_data_rdy = 1'b0;
      #2;
      chk("t1_idle", 64'({bus.wr_done, bus.cmd_en}), 64'b00);

      // Arbitration table.
      for (int i = 0; i < 9; i++) begin
         cyc();
         bus.init_calib_complete = vt[i].calib;
         bus.wr_req = vt[i].wr; bus.rd_req = vt[i].rd; bus.rd_urgent = vt[i].urg;
         bus.wr_addr = 28'(28'hA000 + i); bus.rd_addr = 28'(28'hB000 + i);
         bus.wr_burst = 6'(i % 3); bus.rd_burst = 6'd1;
         #2;
         chk($sformatf("tab%0d_grant", i), 64'({bus.wr_grant, bus.rd_grant}),
             64'({vt[i].exp_wg, vt[i].exp_rg}));
         if (bus.wr_grant || bus.rd_grant) begin
            cyc();
            bus.wr_req = 1'b0; bus.rd_req = 1'b0; bus.rd_urgent = 1'b0;
            #2;
            chk($sformatf("tab%0d_addr", i), 64'(bus.addr),
                vt[i].exp_wg ? 64'(28'hA000 + i) : 64'(28'hB000 + i));
            chk($sformatf("tab%0d_abn", i), 64'(bus.app_burst_number),
                vt[i].exp_wg ? 64'(i % 3) : 64'd1);
            finish_txn();
         end
      end
      bus.init_calib_complete = 1'b1;

      // 2: read burst of 64 beats with gaps.
      cyc();
      bus.wr_req = 1'b0; bus.rd_req = 1'b1; bus.rd_urgent = 1'b0;
      bus.rd_addr = 28'h0ABCDE0; bus.rd_burst = 6'd63;
      wait_grant(w, r, waited);
      chk("t2_grant", 64'({w, r}), 64'b01);
      cyc();
      bus.rd_req = 1'b0; bus.rd_data_valid = 1'b1;
      #2;
      chk("t2_cmd", 64'({bus.cmd_en, bus.cmd}), 64'b1001);
      chk("t2_ignore_in_cmd", 64'(bus.rd_fifo_wr), 64'd0);
      cyc();
      bus.cmd_ready = 1'b1; bus.rd_data_valid = 1'b0;
      #2;
      beats = 0; dones = 0; done_ok = 0; pass_bad = 0; fin = 1'b0;
      for (int i = 0; i < 300 && !fin; i++) begin
         cyc();
         bus.cmd_ready = 1'b0;
         bus.rd_data_valid = ((i % 4) != 2);
         bus.rd_data = 128'(i * 7 + 1);
         #2;
         if (bus.rd_fifo_wr) begin
            beats++;
            if (bus.rd_fifo_data !== 128'(i * 7 + 1)) pass_bad++;
         end
         if (bus.rd_done) begin
            dones++;
            if (beats == 64) done_ok = 1;
            fin = 1'b1;
         end
      end
      chk("t2_beats", 64'(beats), 64'd64);
      chk("t2_done_count", 64'(dones), 64'd1);
      chk("t2_done_on_last", 64'(done_ok), 64'd1);
      chk("t2_passthru", 64'(pass_bad), 64'd0);
      cyc();
      bus.rd_data_valid = 1'b1;
      #2;
      chk("t2_ignore_in_idle", 64'(bus.rd_fifo_wr), 64'd0);
      bus.rd_data_valid = 1'b0;

      // 3: both requests held from reset alternate, back-to-back.
      cyc();
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      bus.wr_req = 1'b1; bus.rd_req = 1'b1; bus.rd_urgent = 1'b0;
      bus.wr_burst = 6'd1; bus.rd_burst = 6'd2;
      for (int k = 0; k < 4; k++) begin
         wait_grant(w, r, waited);
         chk($sformatf("t3_order%0d", k), 64'({w, r}), (k % 2 == 0) ? 64'b10 : 64'b01);
         if (k > 0) chk($sformatf("t3_b2b%0d", k), 64'(waited), 64'd0);
         finish_txn();
      end
      bus.wr_req = 1'b0; bus.rd_req = 1'b0;

      // 4: urgent read arriving during a write waits for it, then wins.
      cyc();
      bus.wr_req = 1'b1; bus.wr_burst = 6'd2;
      wait_grant(w, r, waited);
      chk("t4_wr_grant", 64'({w, r}), 64'b10);
      bad = 0; fin = 1'b0;
      for (int i = 0; i < 50 && !fin; i++) begin
         cyc();
         bus.rd_req = 1'b1; bus.rd_urgent = 1'b1;
         bus.wr_data_rdy = 1'b1; bus.cmd_ready = 1'b1;
         #2;
         if (bus.wr_grant || bus.rd_grant) bad++;
         if (bus.wr_done) fin = 1'b1;
      end
      chk("t4_no_preempt", 64'(bad), 64'd0);
      chk("t4_wr_done", 64'(fin), 64'd1);
      cyc();
      bus.wr_data_rdy = 1'b0; bus.cmd_ready = 1'b0;
      #2;
      chk("t4_urgent_read", 64'({bus.wr_grant, bus.rd_grant}), 64'b01);
      cyc();
      bus.wr_req = 1'b0; bus.rd_req = 1'b0; bus.rd_urgent = 1'b0;
      finish_txn();

      // 5: throttled write data and slow command acceptance.
      cyc();
      bus.wr_req = 1'b1; bus.wr_addr = 28'h0F0F0F0; bus.wr_burst = 6'd4;
      wait_grant(w, r, waited);
      chk("t5_grant", 64'({w, r}), 64'b10);
      cyc();
      bus.wr_req = 1'b0;
      beats = 0; bad = 0; fin = 1'b0;
      for (int i = 0; i < 40 && !fin; i++) begin
         bus.wr_data_rdy = ((i % 2) == 0);
         #2;
         if (bus.wr_data_en) beats++;
         if (bus.wr_data_en && !bus.wr_data_rdy) bad++;
         if (bus.cmd_en) fin = 1'b1;
         else cyc();
      end
      chk("t5_beats", 64'(beats), 64'd5);
      chk("t5_beat_gating", 64'(bad), 64'd0);
      for (int j = 0; j < 5; j++) begin
         cyc();
         bus.wr_data_rdy = 1'b1;
         #2;
         chk($sformatf("t5_hold%0d", j),
             64'({bus.cmd_en, bus.cmd, bus.app_burst_number, bus.wr_data_en, bus.wr_done}),
             64'({1'b1, 3'd0, 6'd4, 1'b0, 1'b0}));
         chk($sformatf("t5_addr%0d", j), 64'(bus.addr), 64'h0F0F0F0);
      end
      cyc();
      bus.cmd_ready = 1'b1;
      #2;
      chk("t5_wr_done", 64'(bus.wr_done), 64'd1);
      cyc();
      bus.cmd_ready = 1'b0; bus.wr_data_rdy = 1'b0;

      // 6: reset mid-read, then calibration gating.
      cyc();
      bus.rd_req = 1'b1; bus.rd_addr = 28'h1234560; bus.rd_burst = 6'd7;
      wait_grant(w, r, waited);
      chk("t6_grant", 64'({w, r}), 64'b01);
      cyc();
      bus.rd_req = 1'b0; bus.cmd_ready = 1'b1;
      #2;
      cyc();
      bus.cmd_ready = 1'b0; bus.rd_data_valid = 1'b1;
      #2;
      chk("t6_in_rd_wait", 64'(bus.rd_fifo_wr), 64'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_strobes", 64'({bus.rd_fifo_wr, bus.rd_done, bus.cmd_en, bus.wr_data_en}), 64'd0);
      chk("t6_rst_addr", 64'(bus.addr), 64'd0);
      chk("t6_rst_abn", 64'(bus.app_burst_number), 64'd0);
      cyc();
      rst_n = 1'b1; bus.rd_data_valid = 1'b0;
      bus.init_calib_complete = 1'b0; bus.wr_req = 1'b1; bus.rd_req = 1'b1;
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         #2;
         if (bus.wr_grant || bus.rd_grant) bad++;
         cyc();
      end
      chk("t6_no_grant_uncal", 64'(bad), 64'd0);
      bus.init_calib_complete = 1'b1;
      #2;
      chk("t6_tie_after_reset", 64'({bus.wr_grant, bus.rd_grant}), 64'b10);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
